if_id_queue: RTL and testbench
==============================

Name: if_id_queue

Overview:
- Decoupling buffer between the fetch stage (program counter plus instruction memory read) and the decode stage.
- Captures each fetched {pc, instruction} pair into a small circular queue and presents the oldest entry to decode with a valid/ready handshake.
- Its full flag drives the fetch-stage stall, so the PC stops advancing while decode is blocked.
- Flushed on branch/jump mispredict so that wrong-path instructions never reach decode.

Parameters:
- DEPTH, 2, number of queue entries; must be a power of two, minimum 2.
- RESET_PC, 32'h0000_3000, value driven on out_pc while the queue is empty.
- NOP_INSTR, 32'h0000_0000, instruction driven on out_instr while the queue is empty (MIPS sll $0,$0,0).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch presents a valid instruction this cycle.
- in_pc  in  32  address of the fetched instruction.
- in_instr  in  32  fetched instruction word.
- in_ready  out  1  queue can accept an entry; fetch uses ~in_ready as its stall.
- flush  in  1  mispredict/redirect; discards all entries.
- out_valid  out  1  head entry is valid for decode.
- out_pc  out  32  head entry PC.
- out_pc4  out  32  head entry PC + 4.
- out_instr  out  32  head entry instruction.
- out_exc  out  1  head entry fetched from a misaligned PC (AdEL).
- out_ready  in  1  decode accepts the head entry this cycle.
- occupancy  out  $clog2(DEPTH)+1  current entry count.

Behaviour:
State:
- Storage arrays pc_q, instr_q, exc_q, each DEPTH entries.
- Pointers wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
- Entry counter count.

Reset (reset==0, asynchronous):
- count=0, wr_ptr=0, rd_ptr=0, all storage cleared to 0.
- Consequences: out_valid=0, in_ready=1, occupancy=0, out_pc=RESET_PC, out_pc4=RESET_PC+4, out_instr=NOP_INSTR, out_exc=0.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.

Handshake:
- push = in_valid & in_ready.
- pop = out_valid & out_ready.
- in_ready = (count != DEPTH); it does not depend on out_ready, so there is no combinational ready path.
- out_valid = (count != 0).

Datapath:
- Outputs are a combinational read of the entry at rd_ptr.
- When count==0, outputs are forced to RESET_PC / RESET_PC+4 / NOP_INSTR / 0.
- out_pc4 = out_pc + 32'd4, modulo 2^32 (0xFFFF_FFFC wraps to 0).

Latency:
- An entry pushed at edge N is visible with out_valid=1 after edge N.
- There is no same-cycle bypass from in_* to out_*.

Pointer and count update (per rising edge, in priority order):
1. flush=1: count, wr_ptr and rd_ptr all go to 0. A concurrent push and pop are both ignored. Storage contents need not be cleared.
2. Otherwise:
   - push: write entry at wr_ptr, then wr_ptr+1.
   - pop: rd_ptr+1.
   - count: +1 for push only, -1 for pop only, unchanged for push and pop together.

Exception tagging:
- exc_q is written with (in_pc[1:0] != 2'b00).
- The entry is still queued; decode converts it to an exception.

Boundary conditions:
- Full with out_ready=1: in_ready stays 0 that cycle. The push is refused, and the freed slot is only visible the following cycle.
- Empty with in_valid=1 and out_ready=1: push only; out_valid=0 that cycle.
- Flush while full: in_ready=1 and out_valid=0 in the next cycle.
- Pointer wrap from DEPTH-1 to 0 must preserve FIFO order.
- in_valid while full: the data is dropped. Fetch must hold its PC, which is guaranteed because fetch stalls on ~in_ready.

Assertions (sim only):
- count never exceeds DEPTH.
- count never underflows.

Decomposition:
- Shared package cpu_pkg holds:
  - RESET_PC = 32'h0000_3000
  - NOP_INSTR = 32'h0
  - EXC_ADEL = 5'd4, used by decode when out_exc=1
  - INSTR_W = 32
- No sub-module is needed. Storage and pointers stay inline; all of it fits in one module of about 150 lines.

Test Plan:
- Reset: hold reset low, then release. Expect out_valid=0, in_ready=1, out_pc=32'h3000, out_pc4=32'h3004, out_instr=0, occupancy=0.
- Basic flow: push {0x3000, 0x2008_0001} with out_ready=1. The next cycle shows out_valid=1, out_pc=0x3000, out_pc4=0x3004, out_instr=0x2008_0001. The pop then returns occupancy to 0.
- Fill and stall: out_ready=0, push 0x3000 and 0x3004. Expect in_ready=0, occupancy=2, and a third push of 0x3008 refused. Then set out_ready=1: expect pops in order 0x3000, 0x3004, then in_ready=1.
- Wrap: stream 8 sequential PCs from 0x3000 with out_ready toggling every cycle. Expect output order exactly 0x3000..0x301C, with no loss or duplication.
- Flush priority: with queue full, assert flush together with in_valid=1 (pc 0x4000) and out_ready=1. Next cycle: occupancy=0, out_valid=0, 0x4000 not queued.
- Misaligned and async reset: push pc 0x3002 and expect out_exc=1 at the head. Then pull reset low between clock edges: out_valid drops to 0 immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Constants shared between the fetch, queue and decode stages.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int          INSTR_W   = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  // MIPS sll $0,$0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  // Exception code decode raises for an entry tagged with out_exc
  localparam logic [4:0]  EXC_ADEL  = 5'd4;

endpackage
`default_nettype wire

// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
// Module      : if_id_queue
// Description : Circular fetch-to-decode buffer with valid/ready handshake,
//               misaligned-PC tagging and mispredict flush.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_queue
  import cpu_pkg::*;
#(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [31:0]              in_pc,
  input  logic [INSTR_W-1:0]       in_instr,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_pc4,
  output logic [INSTR_W-1:0]       out_instr,
  output logic                     out_exc,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

  logic [31:0]          r_pc_q    [DEPTH];
  logic [INSTR_W-1:0]   r_instr_q [DEPTH];
  logic                 r_exc_q   [DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_CNT_W-1:0]   r_count;

  logic                 w_push;
  logic                 w_pop;

  // in_ready depends only on count, so there is no combinational path from out_ready
  assign in_ready  = (r_count != c_FULL);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign occupancy = r_count;

  always_comb begin
    out_pc    = RESET_PC;
    out_instr = NOP_INSTR;
    out_exc   = 1'b0;
    if (out_valid) begin
      out_pc    = r_pc_q[r_rd_ptr];
      out_instr = r_instr_q[r_rd_ptr];
      out_exc   = r_exc_q[r_rd_ptr];
    end
  end

  assign out_pc4 = out_pc + 32'd4;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_q[i]    <= '0;
        r_instr_q[i] <= '0;
        r_exc_q[i]   <= 1'b0;
      end
    end else if (flush) begin
      // Wrong-path entries are abandoned; stale storage is never read while count is 0
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_pc_q[r_wr_ptr]    <= in_pc;
        r_instr_q[r_wr_ptr] <= in_instr;
        r_exc_q[r_wr_ptr]   <= (in_pc[1:0] != 2'b00);
        r_wr_ptr            <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - c_CNT_W'(1);
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset) begin
      assert (r_count <= c_FULL)
        else $error("if_id_queue: count above DEPTH");
      assert (!(r_count == '0 && w_pop && !w_push && !flush))
        else $error("if_id_queue: count underflow");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_id_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_queue
// Description : Scoreboard bench for if_id_queue (DEPTH=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_queue;
  import cpu_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;
  logic [31:0] out_instr;
  logic        out_exc;
  logic        out_ready;
  logic [1:0]  occupancy;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } entry_t;

  entry_t sb[$];
  int     n_checks = 0;
  int     n_pass   = 0;
  logic   acc;

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_pc4   (out_pc4),
    .out_instr (out_instr),
    .out_exc   (out_exc),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // Drives one cycle, checks outputs against the scoreboard, then advances past the edge
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                       input logic rdy, input logic fl, output logic accepted);
    logic m_ready;
    logic m_valid;
    in_valid  = v;
    in_pc     = pc;
    in_instr  = instr;
    out_ready = rdy;
    flush     = fl;
    #1;
    m_ready = (sb.size() < DEPTH);
    m_valid = (sb.size() != 0);
    check("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check("occupancy", {30'd0, occupancy}, sb.size());
    if (m_valid) begin
      check("head_pc", out_pc, sb[0].pc);
      check("head_pc4", out_pc4, sb[0].pc + 32'd4);
      check("head_instr", out_instr, sb[0].instr);
      check("head_exc", {31'd0, out_exc}, {31'd0, sb[0].exc});
    end else begin
      check("empty_pc", out_pc, 32'h0000_3000);
      check("empty_pc4", out_pc4, 32'h0000_3004);
      check("empty_instr", out_instr, 32'h0);
      check("empty_exc", {31'd0, out_exc}, 32'd0);
    end
    accepted = v && m_ready && !fl;
    if (fl) begin
      sb.delete();
    end else begin
      if (rdy && m_valid) void'(sb.pop_front());
      if (accepted) sb.push_back('{pc, instr, (pc[1:0] != 2'b00)});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_instr  = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_occupancy", {30'd0, occupancy}, 32'd0);
    check("rst_pc", out_pc, 32'h0000_3000);
    check("rst_pc4", out_pc4, 32'h0000_3004);
    check("rst_instr", out_instr, 32'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Basic flow: empty push with out_ready high is push only
    drive(1'b1, 32'h0000_3000, 32'h2008_0001, 1'b1, 1'b0, acc);
    check("basic_accept", {31'd0, acc}, 32'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);

    // Fill, refuse third push, then full with out_ready (push still refused)
    drive(1'b1, 32'h0000_3000, 32'h1111_0000, 1'b0, 1'b0, acc);
    drive(1'b1, 32'h0000_3004, 32'h1111_0004, 1'b0, 1'b0, acc);
    drive(1'b1, 32'h0000_3008, 32'h1111_0008, 1'b0, 1'b0, acc);
    check("full_refuse", {31'd0, acc}, 32'd0);
    drive(1'b1, 32'h0000_3008, 32'h1111_0008, 1'b1, 1'b0, acc);
    check("full_pop_refuse", {31'd0, acc}, 32'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);

    // Streaming through the pointer wrap with out_ready toggling
    idx = 0;
    for (int cyc = 0; cyc < 64 && (idx < 8 || sb.size() != 0); cyc++) begin
      drive(idx < 8, 32'h0000_3000 + 32'(idx * 4), {16'hC0DE, 16'(idx)},
            cyc[0], 1'b0, acc);
      if (acc) idx++;
    end
    check("wrap_pushed", idx, 32'd8);
    check("wrap_drained", sb.size(), 32'd0);

    // Flush while full beats a concurrent push and pop
    drive(1'b1, 32'h0000_5000, 32'hAAAA_0000, 1'b0, 1'b0, acc);
    drive(1'b1, 32'h0000_5004, 32'hAAAA_0004, 1'b0, 1'b0, acc);
    drive(1'b1, 32'h0000_4000, 32'hBBBB_0000, 1'b1, 1'b1, acc);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

    // PC+4 wraps modulo 2^32
    drive(1'b1, 32'hFFFF_FFFC, 32'hCCCC_0001, 1'b0, 1'b0, acc);
    check("pc4_wrap", out_pc4, 32'h0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

    // Misaligned PC tagged, then asynchronous reset mid-cycle
    drive(1'b1, 32'h0000_3002, 32'hDDDD_0002, 1'b0, 1'b0, acc);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);
    check("misaligned_exc", {31'd0, out_exc}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_occupancy", {30'd0, occupancy}, 32'd0);
    check("async_exc", {31'd0, out_exc}, 32'd0);
    check("async_pc", out_pc, 32'h0000_3000);
    sb.delete();
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 32'h0000_3010, 32'hEEEE_0010, 1'b1, 1'b0, acc);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
